mem_lc3b_latency: RTL and testbench
===================================

Name: mem_lc3b_latency

Overview:
- Byte-addressable 16-bit main memory for the LC-3b datapath, split into even and odd byte banks.
- Generalises the existing single-cycle memory with a parametrised depth and a fixed multi-cycle access latency.
- Uses a request/ready handshake (mio_en/r) that the control FSM waits on.
- Adds misalignment detection and a registered read path.

Parameters:
- ADDR_W, 16, width of the byte address bus.
- DEPTH_WORDS, 256, number of 16-bit words; power of two, 2..32768.
- LATENCY, 5, cycles from request acceptance to r assertion; integer, >=1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- mio_en  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with the request.
- word  in  1  1 = 16-bit access, 0 = byte access (IR[14] of the ld/st instruction).
- addr  in  ADDR_W  byte address; sampled with the request.
- wdata  in  16  write data; for byte writes only [7:0] is used.
- rdata  out  16  word data, or sign-extended byte; registered.
- ir_out  out  16  raw word {odd, even} at the accepted word address; registered; used for instruction fetch.
- r  out  1  ready; 1-cycle pulse marking completion.
- busy  out  1  1 from acceptance until r is asserted.
- err  out  1  misaligned word access; valid only while r=1.

Behaviour:
- Storage:
  - Two banks of DEPTH_WORDS x 8 bits: even = byte address bit0 = 0, odd = bit0 = 1.
  - Word index = addr[log2(DEPTH_WORDS):1]; higher address bits are ignored (aliasing).
- Reset (reset=0 at a rising edge):
  - Outputs: r=0, busy=0, err=0, rdata=0, ir_out=0; FSM goes to IDLE; counter cleared.
  - Memory contents are not changed.
  - Reset during WAIT aborts the access: no write occurs and no r pulse is produced.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if mio_en=1 at an edge, latch we, word, addr, wdata; load counter with LATENCY-1; set busy=1. If LATENCY=1 go directly to DONE, otherwise go to WAIT.
  - WAIT: decrement the counter each edge. At the edge where the counter is 1, go to DONE and perform the completion actions.
  - DONE: r=1 and busy=0 for exactly one cycle, then unconditionally go to IDLE.
  - mio_en is ignored while in DONE. A request still held high in the following IDLE cycle starts a new access, so the control FSM must drop mio_en on seeing r.
- Timing:
  - Request sampled at edge E0 gives r=1 in the cycle after edge E0+LATENCY-1. Example: with LATENCY=5 and E0 at cycle 0, r is high in cycle 5.
  - Back-to-back throughput is one access per LATENCY+1 cycles.
- Completion actions (on the edge entering DONE):
  - Misaligned access (word=1, addr[0]=1): err=1, no bank written, rdata=0; ir_out is still loaded.
  - Word read: rdata = {odd, even}.
  - Word write: even <= wdata[7:0], odd <= wdata[15:8]; rdata = new word.
  - Byte read: rdata = sign-extended addressed byte (even if addr[0]=0, else odd).
  - Byte write: only the addressed bank is written, with wdata[7:0]. The other bank is untouched. rdata = sign-extended written byte.
  - ir_out = {odd, even} at the word index, after any write.
- Hold behaviour: rdata and ir_out hold their values until the next completion. err is 0 whenever r=0.
- Inputs change freely during WAIT; only the latched copies are used.

Test Plan:
- LATENCY=5; word write addr=0x0010, wdata=0xBEEF, request at cycle 0 -> busy high in cycles 1-4; r=1 only in cycle 5; err=0. A following word read of 0x0010 -> rdata=0xBEEF, ir_out=0xBEEF.
- Byte writes: 0x80 to addr 0x0021, then 0x7F to addr 0x0020. Byte reads then return 0x0021 -> rdata=0xFF80 and 0x0020 -> rdata=0x007F; word read 0x0020 -> 0x807F (no lane corruption).
- Word read at addr=0x0011 -> r pulse with err=1, rdata=0x0000. A word write at 0x0011 with 0x1234 -> err=1, and a subsequent word read of 0x0010 is unchanged.
- Word write 0x5555 to 0x0030, with reset=0 asserted in cycle 2 (mid-WAIT) -> no r pulse, busy=0 after the reset edge; a later read of 0x0030 returns the old value.
- mio_en held high continuously -> r pulses every LATENCY+1 cycles (cycles 5, 11, 17 for LATENCY=5). Repeat with LATENCY=1 -> r in cycles 1, 3, 5.
- DEPTH_WORDS=256: word write 0xA5A5 to addr 0x0202 -> word read of 0x0002 returns 0xA5A5 (aliasing).

Source files
------------

// File: rtl/mem_lc3b_latency.sv
// Byte-addressable 16-bit LC-3b main memory (even/odd byte banks) with a fixed
// multi-cycle access latency, mio_en/r handshake, misalignment flag and registered read path.
module mem_lc3b_latency #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mio_en,
  input  logic              we,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic [15:0]       ir_out,
  output logic              r,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    sext8 = {{8{b[7]}}, b};
  endfunction

  logic [7:0]        mem_even_r [0:DEPTH_WORDS-1];
  logic [7:0]        mem_odd_r  [0:DEPTH_WORDS-1];

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              accept_s, complete_s;

  logic              we_r, word_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       wdata_r;

  logic              req_we_s, req_word_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [15:0]       req_wdata_s;
  logic [IDX_W-1:0]  idx_s;
  logic              mis_s, wr_even_s, wr_odd_s;
  logic [7:0]        even_new_s, odd_new_s;
  logic [15:0]       rdata_next_s;
  logic              unused_addr_s;

  logic              r_r, busy_r, err_r;
  logic [15:0]       rdata_r, ir_r;

  // Next-state logic: accept in IDLE, count down in WAIT, one-cycle DONE.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    complete_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mio_en) begin
          accept_s   = 1'b1;
          cnt_next_s = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_next_s = ST_DONE;
            complete_s   = 1'b1;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = ST_DONE;
          complete_s   = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // With LATENCY=1 completion happens on the accepting edge, so use live inputs then.
  always_comb begin
    if (accept_s) begin
      req_we_s    = we;
      req_word_s  = word;
      req_addr_s  = addr;
      req_wdata_s = wdata;
    end else begin
      req_we_s    = we_r;
      req_word_s  = word_r;
      req_addr_s  = addr_r;
      req_wdata_s = wdata_r;
    end
  end

  // Completion datapath: bank write enables, post-write bytes and read result.
  always_comb begin
    idx_s     = req_addr_s[IDX_W:1];
    mis_s     = req_word_s & req_addr_s[0];
    wr_even_s = complete_s & reset & req_we_s & ~mis_s & (req_word_s | ~req_addr_s[0]);
    wr_odd_s  = complete_s & reset & req_we_s & ~mis_s & (req_word_s |  req_addr_s[0]);
    if (wr_even_s) begin
      even_new_s = req_wdata_s[7:0];
    end else begin
      even_new_s = mem_even_r[idx_s];
    end
    if (wr_odd_s) begin
      odd_new_s = req_word_s ? req_wdata_s[15:8] : req_wdata_s[7:0];
    end else begin
      odd_new_s = mem_odd_r[idx_s];
    end
    if (mis_s) begin
      rdata_next_s = 16'h0000;
    end else if (req_word_s) begin
      rdata_next_s = {odd_new_s, even_new_s};
    end else if (req_addr_s[0]) begin
      rdata_next_s = sext8(odd_new_s);
    end else begin
      rdata_next_s = sext8(even_new_s);
    end
  end

  // Address bits above the word index alias and are deliberately ignored.
  assign unused_addr_s = ^(req_addr_s >> (IDX_W + 1));

  // Byte banks; no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_even_s) begin
      mem_even_r[idx_s] <= even_new_s;
    end
    if (wr_odd_s) begin
      mem_odd_r[idx_s] <= odd_new_s;
    end
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      word_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 16'h0000;
      r_r     <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 16'h0000;
      ir_r    <= 16'h0000;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      r_r     <= complete_s;
      busy_r  <= (state_next_s == ST_WAIT);
      err_r   <= complete_s & mis_s;
      if (accept_s) begin
        we_r    <= we;
        word_r  <= word;
        addr_r  <= addr;
        wdata_r <= wdata;
      end
      if (complete_s) begin
        rdata_r <= rdata_next_s;
        ir_r    <= {odd_new_s, even_new_s};
      end
    end
  end

  assign rdata  = rdata_r;
  assign ir_out = ir_r;
  assign r      = r_r;
  assign busy   = busy_r;
  assign err    = err_r;

endmodule

// File: tb/tb_mem_lc3b_latency.sv
// Scoreboard bench for mem_lc3b_latency: byte-array reference model, directed cases
// from the test plan, then randomized accesses; a second instance covers LATENCY=1.
module tb_mem_lc3b_latency;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        mio_en, we, word;
  logic [15:0] addr, wdata;
  logic [15:0] rdata, ir_out;
  logic        r, busy, err;

  logic        mio_en1, we1, word1;
  logic [15:0] addr1, wdata1;
  logic [15:0] rdata1, ir1;
  logic        r1, busy1, err1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] ir;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  model[0:511];

  always #5 clk = ~clk;

  mem_lc3b_latency #(.ADDR_W(16), .DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mio_en(mio_en), .we(we), .word(word), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ir_out(ir_out), .r(r), .busy(busy), .err(err)
  );

  mem_lc3b_latency #(.ADDR_W(16), .DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mio_en(mio_en1), .we(we1), .word(word1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .ir_out(ir1), .r(r1), .busy(busy1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte memory of 512 bytes (256 words); little-endian word = {a+1, a}.
  task automatic model_access(input logic w, input logic wd, input logic [15:0] a,
                              input logic [15:0] d);
    int   b, base;
    exp_t x;
    b    = int'(a) % 512;
    base = b - (b % 2);
    x.e  = 1'b0;
    if (wd && (b % 2 == 1)) begin
      x.e  = 1'b1;
      x.rd = 16'h0000;
    end else if (wd) begin
      if (w) begin
        model[base]     = d[7:0];
        model[base + 1] = d[15:8];
      end
      x.rd = 16'(model[base + 1]) * 16'd256 + 16'(model[base]);
    end else begin
      if (w) model[b] = d[7:0];
      x.rd = (model[b] >= 8'd128) ? 16'(model[b]) + 16'hFF00 : 16'(model[b]);
    end
    x.ir = 16'(model[base + 1]) * 16'd256 + 16'(model[base]);
    q.push_back(x);
  endtask

  // One access on the LATENCY=5 instance; checks busy/r timing, leaves DUT in IDLE.
  task automatic access(input logic w, input logic wd, input logic [15:0] a,
                        input logic [15:0] d);
    model_access(w, wd, a, d);
    mio_en = 1'b1; we = w; word = wd; addr = a; wdata = d;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mio_en = 1'b0;
        we     = 1'($urandom);
        word   = 1'($urandom);
        addr   = 16'($urandom);
        wdata  = 16'($urandom);
      end
      if (k < LAT) begin
        chk("busy_wait", {31'd0, busy}, 32'd1);
        chk("r_early", {31'd0, r}, 32'd0);
      end else begin
        chk("r_done", {31'd0, r}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd0);
      end
    end
    @(negedge clk);
  endtask

  // Monitor: pops an expectation on every r pulse; err must be low otherwise.
  always @(negedge clk) begin
    if (r === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_r", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("rdata", {16'd0, rdata}, {16'd0, x.rd});
        chk("ir_out", {16'd0, ir_out}, {16'd0, x.ir});
        chk("err", {31'd0, err}, {31'd0, x.e});
      end
    end else if (reset === 1'b1) begin
      chk("err_idle", {31'd0, err}, 32'd0);
    end
  end

  initial begin
    reset = 1'b0; mio_en = 1'b0; we = 1'b0; word = 1'b0; addr = 16'h0; wdata = 16'h0;
    mio_en1 = 1'b0; we1 = 1'b0; word1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_r", {31'd0, r}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_ir", {16'd0, ir_out}, 32'd0);
    chk("rst_r1", {31'd0, r1}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // LATENCY=1 instance: continuous write request, then a read back.
    mio_en1 = 1'b1; we1 = 1'b1; word1 = 1'b1; addr1 = 16'h0004; wdata1 = 16'h1234;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("lat1_r", {31'd0, r1}, {31'd0, (k == 1 || k == 3 || k == 5)});
      chk("lat1_busy", {31'd0, busy1}, 32'd0);
      if (k == 6) we1 = 1'b0;
    end
    @(negedge clk);
    mio_en1 = 1'b0;
    chk("lat1_r_rd", {31'd0, r1}, 32'd1);
    chk("lat1_rdata", {16'd0, rdata1}, 32'h1234);
    chk("lat1_ir", {16'd0, ir1}, 32'h1234);
    chk("lat1_err", {31'd0, err1}, 32'd0);
    @(negedge clk);

    // Prefill bytes 0x00..0x3F so every later read has a defined value.
    for (int i = 0; i < 64; i += 2) access(1'b1, 1'b1, 16'(i), 16'($urandom));

    access(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    access(1'b0, 1'b1, 16'h0010, 16'h0000);
    access(1'b1, 1'b0, 16'h0021, 16'h0080);
    access(1'b1, 1'b0, 16'h0020, 16'hAB7F);
    access(1'b0, 1'b0, 16'h0021, 16'h0000);
    access(1'b0, 1'b0, 16'h0020, 16'h0000);
    access(1'b0, 1'b1, 16'h0020, 16'h0000);
    access(1'b0, 1'b1, 16'h0011, 16'h0000);
    access(1'b1, 1'b1, 16'h0011, 16'h1234);
    access(1'b0, 1'b1, 16'h0010, 16'h0000);

    // Reset mid-WAIT aborts the write with no r pulse.
    mio_en = 1'b1; we = 1'b1; word = 1'b1; addr = 16'h0030; wdata = 16'h5555;
    @(negedge clk);
    mio_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_r", {31'd0, r}, 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    access(1'b0, 1'b1, 16'h0030, 16'h0000);

    // mio_en held high: completions at cycles 5, 11, 17.
    for (int i = 0; i < 3; i++) model_access(1'b0, 1'b1, 16'h0010, 16'h0000);
    mio_en = 1'b1; we = 1'b0; word = 1'b1; addr = 16'h0010;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk("stream_r", {31'd0, r}, {31'd0, (k == 5 || k == 11 || k == 17)});
      if (k == 18) mio_en = 1'b0;
    end
    @(negedge clk);

    access(1'b1, 1'b1, 16'h0202, 16'hA5A5);
    access(1'b0, 1'b1, 16'h0002, 16'h0000);

    // Random accesses in the prefilled region, with random aliasing upper bits.
    for (int i = 0; i < 120; i++) begin
      logic [15:0] a;
      a = (16'($urandom) & 16'hFE00) | 16'($urandom_range(0, 63));
      access(1'($urandom), 1'($urandom), a, 16'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
